dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported, byte-addressed, big-endian data memory (combinational read, write on clock negedge).
- Port 0 is the CPU load/store unit. Port 1 is the loader/debug/DMA master.
- Runs one word transaction per grant through a 3-state FSM, round-robin between ports.
- Drives the memory's address, write-data and write-enable inputs, and returns captured read data with a one-cycle ack.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; last legal word address is MEM_BYTES-4.
- ADDR_W, 32, address width of requester and memory ports.

Ports:
- clk  in  1  system clock, posedge-registered logic.
- rst_n  in  1  synchronous active-low reset.
- m0_req  in  1  port 0 request; held high until m0_ack.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_W  port 0 byte address.
- m0_wdata  in  32  port 0 write word.
- m0_ack  out  1  port 0 one-cycle completion pulse.
- m0_rdata  out  32  port 0 read word, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1.
- mem_addr  out  ADDR_W  to memory address input.
- mem_data_in  out  32  to memory write-data input.
- mem_wr  out  1  to memory write enable.
- mem_data_out  in  32  from memory read data.
- busy  out  1  high in any state except IDLE.
- grant_id  out  1  port currently or last served.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; m0_ack=m1_ack=0; mem_wr=0.
  - mem_addr=0; mem_data_in=0; m0_rdata=m1_rdata=0.
  - grant_id=1, so port 0 wins the first tie.
  - busy=0.
  - Reset mid-transaction aborts it: no ack is issued, and mem_wr is 0 from the next cycle.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the port != grant_id wins (round-robin).
  - On a win: latch the winner's addr/we/wdata into mem_addr/mem_data_in/we_q, set grant_id=winner, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr/mem_data_in held; mem_wr=we_q. The memory commits the write at the mid-cycle negedge.
  - At the closing posedge, capture mem_data_out into the winner's rdata (reads only; a write leaves rdata unchanged).
  - Go to RESP.
- RESP (exactly 1 cycle):
  - mem_wr=0; winner's ack=1; the other ack=0.
  - Go to IDLE.
- Latency: req sampled in IDLE → ack 2 cycles later. Throughput is 1 access per 3 cycles.
- A registered requester drops req in the cycle after ack. IDLE samples req low, so there are no duplicate accesses.
- A req still high in IDLE after ack counts as a new transaction.
- rdata holds its value until that port's next read completes.
- Requester inputs are ignored outside IDLE; latched values are used throughout.
- mem_addr/mem_data_in hold their last values in IDLE and RESP.
- No address arithmetic inside the block: the memory forms the byte lanes (addr..addr+3, MSB first).

Optional Feature:
- Macro: DMEM_ARB_ERR_EN.
- Defined:
  - Adds ports m0_err/m1_err (out, 1), pulsed together with ack.
  - A transaction with addr[1:0]!=0 or addr > MEM_BYTES-4 is flagged at the IDLE latch.
  - A flagged transaction still goes through ACCESS, but with mem_wr forced to 0.
  - For a flagged read, rdata is forced to 32'h0.
  - Both err outputs reset to 0.
- Undefined:
  - No err ports; all addresses pass through unchanged.
  - Out-of-range reads return whatever the memory returns (0 for addr ≥ MEM_BYTES-3).
  - Misaligned accesses proceed.

Test Plan:
- Reset, then m0 write addr=0x10 wdata=0xDEADBEEF → mem_wr=1 for exactly one cycle with mem_addr=0x10; m0_ack 2 cycles after req sampled. A following m0 read of 0x10 → m0_rdata=0xDEADBEEF with ack.
- m0 and m1 both req reads continuously from reset → grants alternate 0,1,0,1; acks spaced 3 cycles apart; grant_id toggles.
- Only m1 req, 3 back-to-back writes → all granted to m1 with no idle gap beyond the FSM cycle; m0_ack stays 0.
- rst_n=0 during ACCESS of a write to 0x20 → no ack; mem_wr=0 the next cycle; busy=0; grant_id=1.
- DMEM_ARB_ERR_EN defined:
  - m0 write addr=0x3FE → err=1 and ack=1; mem_wr never asserted.
  - Read addr=0x3FD → rdata=0, err=1.
  - Read addr=0x3FC → err=0, normal data.
- m1 read after m0 write of 0x12345678 to 0x40 → m1_rdata=0x12345678; m0_rdata unchanged.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter_if : requester-side and memory-side bundle of dmem_arbiter
// Rev 1.0 -- DMEM_ARB_ERR_EN adds the per-port m0_err/m1_err pulses
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_ack;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_ack;
  logic [31:0]       m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in;
  logic              mem_wr;
  logic [31:0]       mem_data_out;

  logic              busy;
  logic              grant_id;
`ifdef DMEM_ARB_ERR_EN
  logic              m0_err;
  logic              m1_err;
`endif

  // slave: the arbiter itself; master: requesters plus the memory beside them
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_data_out,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_data_in, mem_wr,
    output busy, grant_id
`ifdef DMEM_ARB_ERR_EN
    , output m0_err, m1_err
`endif
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_data_out,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_data_in, mem_wr,
    input  busy, grant_id
`ifdef DMEM_ARB_ERR_EN
    , input m0_err, m1_err
`endif
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : round-robin two-port sequencer in front of the data memory
// Rev 1.0 -- DMEM_ARB_ERR_EN flags misaligned/out-of-range word accesses
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;

  logic              any_req;
  logic              pick1;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [31:0]       pick_wdata;
  logic [31:0]       rd_word;
  logic              wr_block;

  // Both requesting: the port that was not served last wins.
  assign any_req    = bus.m0_req | bus.m1_req;
  assign pick1      = bus.m1_req & (~bus.m0_req | ~grant_q);
  assign pick_we    = pick1 ? bus.m1_we    : bus.m0_we;
  assign pick_addr  = pick1 ? bus.m1_addr  : bus.m0_addr;
  assign pick_wdata = pick1 ? bus.m1_wdata : bus.m0_wdata;

`ifdef DMEM_ARB_ERR_EN
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  logic flag_q, flag_d;
  logic err0_q, err0_d;
  logic err1_q, err1_d;
  logic pick_bad;

  assign pick_bad = (pick_addr[1:0] != 2'b00) || (pick_addr > LAST_WORD);
  assign rd_word  = flag_q ? 32'h0 : bus.mem_data_out;
  assign wr_block = flag_q;

  always_comb begin
    flag_d = flag_q;
    err0_d = 1'b0;
    err1_d = 1'b0;
    if (state_q == ST_IDLE && any_req) begin
      flag_d = pick_bad;
    end
    if (state_q == ST_ACCESS) begin
      err0_d = flag_q & ~grant_q;
      err1_d = flag_q &  grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end

  assign bus.m0_err = err0_q;
  assign bus.m1_err = err1_q;
`else
  assign rd_word  = bus.mem_data_out;
  assign wr_block = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick1;
          we_d    = pick_we;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Memory read data is stable by the closing edge of this cycle.
        if (!we_q) begin
          if (grant_q) begin
            rdata1_d = rd_word;
          end else begin
            rdata0_d = rd_word;
          end
        end
        ack0_d  = ~grant_q;
        ack1_d  =  grant_q;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.mem_wr      = (state_q == ST_ACCESS) && we_q && !wr_block;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.m0_ack      = ack0_q;
  assign bus.m1_ack      = ack1_q;
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter : directed scoreboard bench for dmem_arbiter, with a
// byte-wide big-endian memory model (combinational read, negedge write).
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

  always_comb begin
    bus.mem_data_out = 32'h0;
    if (bus.mem_addr <= 32'(MEM_BYTES - 4))
      bus.mem_data_out = {mem[bus.mem_addr[9:0]],         mem[bus.mem_addr[9:0] + 10'd1],
                          mem[bus.mem_addr[9:0] + 10'd2], mem[bus.mem_addr[9:0] + 10'd3]};
  end

  always @(negedge clk) begin
    if (bus.mem_wr) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_addr + 32'(k) < 32'(MEM_BYTES))
          mem[bus.mem_addr[9:0] + 10'(k)] <= bus.mem_data_in[31-8*k -: 8];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_ack_cyc = 0;
  int    prev_ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected none (cycle %0d)", name, act, cyc);
  endtask

  // Response monitor: pops one expectation per ack pulse.
  always @(negedge clk) begin : mon_resp
    resp_t e;
    if (rst_n && (bus.m0_ack || bus.m1_ack)) begin
      prev_ack_cyc = last_ack_cyc;
      last_ack_cyc = cyc;
      if (bus.m0_ack && bus.m1_ack) begin
        flag_fail("dual_ack", {30'h0, bus.m1_ack, bus.m0_ack});
      end else if (resp_q.size() == 0) begin
        flag_fail("unexpected_ack", {31'h0, bus.m1_ack});
      end else begin
        e = resp_q.pop_front();
        check("ack_port", {31'h0, bus.m1_ack}, {31'h0, e.port});
        check("grant_id", {31'h0, bus.grant_id}, {31'h0, e.port});
        if (!e.we)
          check("rdata", e.port ? bus.m1_rdata : bus.m0_rdata, e.rdata);
`ifdef DMEM_ARB_ERR_EN
        check("err", {31'h0, e.port ? bus.m1_err : bus.m0_err}, {31'h0, e.err});
`endif
      end
    end
  end

  // Memory-write monitor: every mem_wr cycle must match one expected write.
  always @(negedge clk) begin : mon_wr
    wr_t w;
    if (bus.mem_wr) begin
      if (wr_q.size() == 0) begin
        flag_fail("unexpected_mem_wr", bus.mem_addr);
      end else begin
        w = wr_q.pop_front();
        check("mem_addr", bus.mem_addr, w.addr);
        check("mem_data_in", bus.mem_data_in, w.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // One transaction from an idle arbiter; req dropped the cycle after ack.
  task automatic send(input logic port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic exp_memwr);
    int n;
    resp_q.push_back('{port: port, we: we, rdata: exp_rdata, err: exp_err});
    if (exp_memwr) wr_q.push_back('{addr: addr, data: wdata});
    drive(port, 1'b1, we, addr, wdata);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(port ? bus.m1_ack : bus.m0_ack) && n < 20);
    check("ack_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int t [4];
    int n;

    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
    do_reset();

    // reset state
    check("rst_busy",     {31'h0, bus.busy},     32'h0);
    check("rst_grant_id", {31'h0, bus.grant_id}, 32'h1);
    check("rst_mem_wr",   {31'h0, bus.mem_wr},   32'h0);
    check("rst_m0_ack",   {31'h0, bus.m0_ack},   32'h0);
    check("rst_m1_ack",   {31'h0, bus.m1_ack},   32'h0);
    check("rst_mem_addr", bus.mem_addr,          32'h0);
    check("rst_mem_din",  bus.mem_data_in,       32'h0);
    check("rst_m0_rdata", bus.m0_rdata,          32'h0);
    check("rst_m1_rdata", bus.m1_rdata,          32'h0);

    // write then read back on port 0
    send(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // cross-port: port 0 writes, port 1 reads; port 0 rdata holds
    send(1'b0, 1'b1, 32'h40, 32'h12345678, 32'h0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, 1'b0);
    check("m0_rdata_hold", bus.m0_rdata, 32'hDEADBEEF);

    // port 1 back-to-back writes: one access every 3 cycles
    send(1'b1, 1'b1, 32'h80, 32'hAAAA0001, 32'h0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 32'h84, 32'hBBBB0002, 32'h0, 1'b0, 1'b1);
    check("b2b_spacing1", 32'(last_ack_cyc - prev_ack_cyc), 32'd3);
    send(1'b1, 1'b1, 32'h88, 32'hCCCC0003, 32'h0, 1'b0, 1'b1);
    check("b2b_spacing2", 32'(last_ack_cyc - prev_ack_cyc), 32'd3);
    send(1'b0, 1'b0, 32'h84, 32'h0, 32'hBBBB0002, 1'b0, 1'b0);

    // both ports request continuously from reset: 0,1,0,1
    do_reset();
    resp_q.push_back('{port: 1'b0, we: 1'b0, rdata: 32'hAAAA0001, err: 1'b0});
    resp_q.push_back('{port: 1'b1, we: 1'b0, rdata: 32'hCCCC0003, err: 1'b0});
    resp_q.push_back('{port: 1'b0, we: 1'b0, rdata: 32'hAAAA0001, err: 1'b0});
    resp_q.push_back('{port: 1'b1, we: 1'b0, rdata: 32'hCCCC0003, err: 1'b0});
    drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0);
    got = 0;
    n = 0;
    while (got < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.m0_ack || bus.m1_ack) begin
        t[got] = n;
        got++;
      end
    end
    check("rr_ack_count", 32'(got), 32'd4);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    if (got == 4) begin
      check("rr_first_latency", 32'(t[0]), 32'd2);
      for (int i = 1; i < 4; i++)
        check("rr_spacing", 32'(t[i] - t[i-1]), 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rr_idle_busy", {31'h0, bus.busy}, 32'h0);

    // boundary addresses
    send(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
`ifdef DMEM_ARB_ERR_EN
    send(1'b0, 1'b1, 32'h3FE, 32'h11223344, 32'h0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 32'h3FD, 32'h0, 32'h0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
`else
    send(1'b0, 1'b1, 32'h3FE, 32'h11223344, 32'h0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 32'h3FD, 32'h0, 32'h0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 32'h3FC, 32'h0, 32'hCAFE1122, 1'b0, 1'b0);
`endif

    // reset during ACCESS of a write: the negedge write lands, no ack follows
    check("pre_abort_grant", {31'h0, bus.grant_id}, 32'h0);
    wr_q.push_back('{addr: 32'h20, data: 32'h55AA55AA});
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
    @(posedge clk); #1;
    check("abort_in_access_busy", {31'h0, bus.busy},   32'h1);
    check("abort_in_access_wr",   {31'h0, bus.mem_wr}, 32'h1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("abort_mem_wr",   {31'h0, bus.mem_wr},   32'h0);
    check("abort_busy",     {31'h0, bus.busy},     32'h0);
    check("abort_grant_id", {31'h0, bus.grant_id}, 32'h1);
    check("abort_m0_ack",   {31'h0, bus.m0_ack},   32'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("wr_queue_empty",   32'(wr_q.size()),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
